// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the request, shared-ALU and response buses of alu_arbiter.
//   req_*  : two requesters (bit i / suffix i = requester i)
//   alu_*  : operands/opcode/clear out to the shared ALU, result back
//   rsp_*  : per-requester response valid/ready with shared data/error
// Modports:
//   slave  - the arbiter view (takes requests, drives ALU and responses)
//   master - the environment view (requesters plus the ALU itself)
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_dataA0;
    logic [WIDTH-1:0] req_dataA1;
    logic [WIDTH-1:0] req_dataB0;
    logic [WIDTH-1:0] req_dataB1;
    logic [5:0]       req_Signal0;
    logic [5:0]       req_Signal1;
    logic [WIDTH-1:0] alu_dataA;
    logic [WIDTH-1:0] alu_dataB;
    logic [5:0]       alu_Signal;
    logic             alu_reset;
    logic [WIDTH-1:0] alu_dataOut;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  req_valid, req_dataA0, req_dataA1, req_dataB0, req_dataB1,
        input  req_Signal0, req_Signal1,
        output req_ready,
        output alu_dataA, alu_dataB, alu_Signal, alu_reset,
        input  alu_dataOut,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_dataA0, req_dataA1, req_dataB0, req_dataB1,
        output req_Signal0, req_Signal1,
        input  req_ready,
        input  alu_dataA, alu_dataB, alu_Signal, alu_reset,
        output alu_dataOut,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one multi-cycle ALU between two requesters. One operation is in
// flight at a time: IDLE (grant) -> EXEC (ALU_LAT cycles) -> RESP (until the
// granted requester accepts). Illegal opcodes skip EXEC and answer with
// result 0 and rsp_err=1.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, release synchronised internally
//   bus    - alu_arbiter_if.slave (requests, shared ALU, responses)
// Parameters:
//   WIDTH   - operand/result width
//   ALU_LAT - ALU settle cycles per operation (1..4)
// Build option:
//   ALU_ARB_PRIO_EN - when defined, requester 0 always wins a tie (fixed
//                     priority, no pointer); otherwise round-robin.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] LAST_CNT = 2'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             run_q, run_d;
`ifndef ALU_ARB_PRIO_EN
    logic             ptr_q, ptr_d;
`endif
    logic             grant_q, grant_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       req_ready_q, req_ready_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [5:0]       alu_op_q, alu_op_d;
    logic             alu_reset_q, alu_reset_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             win_s;
    logic             hs_s;
    logic             hs_id_s;
    logic             rsp_ack_s;
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;
    logic [5:0]       op_in_s;

    // Opcodes the ALU understands: ADD, SUB, AND, OR, SLT.
    function automatic logic legal_op(input logic [5:0] op);
        logic ok;
        case (op)
            6'd32, 6'd34, 6'd36, 6'd37, 6'd42: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] id_to_vec(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Arbitration winner among the currently valid requests.
    always_comb begin
        win_s = 1'b0;
        if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ptr_q;
`endif
        end else if (bus.req_valid == 2'b10) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Handshake detection and selection of the granted requester's payload.
    // req_ready is one-hot, so its bit 1 is the accepted requester's id.
    always_comb begin
        hs_s    = |(bus.req_valid & req_ready_q);
        hs_id_s = req_ready_q[1];
        if (hs_id_s) begin
            a_in_s  = bus.req_dataA1;
            b_in_s  = bus.req_dataB1;
            op_in_s = bus.req_Signal1;
        end else begin
            a_in_s  = bus.req_dataA0;
            b_in_s  = bus.req_dataB0;
            op_in_s = bus.req_Signal0;
        end
        rsp_ack_s = bus.rsp_ready[grant_q];
    end

    // Next-state and next-output logic of the IDLE/EXEC/RESP controller.
    always_comb begin
        state_d     = state_q;
        run_d       = 1'b1;
`ifndef ALU_ARB_PRIO_EN
        ptr_d       = ptr_q;
`endif
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_reset_d = alu_reset_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    grant_d = hs_id_s;
`ifndef ALU_ARB_PRIO_EN
                    ptr_d   = ~hs_id_s;
`endif
                    cnt_d   = 2'd0;
                    if (legal_op(op_in_s)) begin
                        state_d     = EXEC;
                        alu_a_d     = a_in_s;
                        alu_b_d     = b_in_s;
                        alu_op_d    = op_in_s;
                        alu_reset_d = 1'b0;
                    end else begin
                        // Answer immediately; the ALU is never touched.
                        state_d     = RESP;
                        rsp_valid_d = id_to_vec(hs_id_s);
                        rsp_data_d  = {WIDTH{1'b0}};
                        rsp_err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    // Last settle cycle: capture result, park the ALU.
                    state_d     = RESP;
                    rsp_valid_d = id_to_vec(grant_q);
                    rsp_data_d  = bus.alu_dataOut;
                    rsp_err_d   = 1'b0;
                    alu_a_d     = {WIDTH{1'b0}};
                    alu_b_d     = {WIDTH{1'b0}};
                    alu_op_d    = 6'd0;
                    alu_reset_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (rsp_ack_s) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                    rsp_data_d  = {WIDTH{1'b0}};
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                alu_a_d     = {WIDTH{1'b0}};
                alu_b_d     = {WIDTH{1'b0}};
                alu_op_d    = 6'd0;
                alu_reset_d = 1'b1;
                rsp_valid_d = 2'b00;
                rsp_data_d  = {WIDTH{1'b0}};
                rsp_err_d   = 1'b0;
            end
        endcase

        // Offer a grant only in cycles that will be spent in IDLE, and only
        // once reset release has been synchronised.
        if ((state_d == IDLE) && run_q && (bus.req_valid != 2'b00)) begin
            req_ready_d = id_to_vec(win_s);
        end else begin
            req_ready_d = 2'b00;
        end
    end

    // State and output registers; asynchronous clear on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
`ifndef ALU_ARB_PRIO_EN
            ptr_q       <= 1'b0;
`endif
            grant_q     <= 1'b0;
            cnt_q       <= 2'd0;
            req_ready_q <= 2'b00;
            alu_a_q     <= {WIDTH{1'b0}};
            alu_b_q     <= {WIDTH{1'b0}};
            alu_op_q    <= 6'd0;
            alu_reset_q <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= {WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
`ifndef ALU_ARB_PRIO_EN
            ptr_q       <= ptr_d;
`endif
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_reset_q <= alu_reset_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.alu_dataA  = alu_a_q;
    assign bus.alu_dataB  = alu_b_q;
    assign bus.alu_Signal = alu_op_q;
    assign bus.alu_reset  = alu_reset_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. dut1 (ALU_LAT=1) covers reset values,
// release timing, every opcode, illegal opcodes and response back-pressure;
// dut4 (ALU_LAT=4) covers tie arbitration and reset during EXEC.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    logic       clk;
    logic       rst1;
    logic       rst4;
    int         n_vec  = 0;
    int         n_miss = 0;
    int         k;
    logic [1:0] exp_v;
    logic       seen;

    alu_arbiter_if #(.WIDTH(32)) b1 ();
    alu_arbiter_if #(.WIDTH(32)) b4 ();

    alu_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(b1));
    alu_arbiter #(.WIDTH(32), .ALU_LAT(4)) dut4 (.clk(clk), .reset(rst4), .bus(b4));

    // Behaviour of the external shared ALU.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] op);
        case (op)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign b1.alu_dataOut = alu_model(b1.alu_dataA, b1.alu_dataB, b1.alu_Signal);
    assign b4.alu_dataOut = alu_model(b4.alu_dataA, b4.alu_dataB, b4.alu_Signal);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise a request on dut1, wait (bounded) for its grant, complete the
    // handshake and drop valid. Returns in the first cycle after handshake.
    task automatic issue1(input bit id, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int w;
        if (id) begin
            b1.req_dataA1  = a;
            b1.req_dataB1  = b;
            b1.req_Signal1 = op;
        end else begin
            b1.req_dataA0  = a;
            b1.req_dataB0  = b;
            b1.req_Signal0 = op;
        end
        b1.req_valid[id] = 1'b1;
        w = 0;
        while (b1.req_ready[id] !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("grant_wait", 32'(w < 20), 32'd1);
        tick();
        b1.req_valid[id] = 1'b0;
    endtask

    // Full legal operation on dut1 with rsp_ready held high.
    task automatic op1(input string tag, input bit id, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        issue1(id, op, a, b);
        chk({tag, "_exec_ready"}, 32'(b1.req_ready), 32'd0);
        tick();
        chk({tag, "_vld"}, 32'(b1.rsp_valid), id ? 32'd2 : 32'd1);
        chk({tag, "_data"}, b1.rsp_data, exp);
        chk({tag, "_err"}, 32'(b1.rsp_err), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(b1.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b0;
        rst4 = 1'b0;
        b1.req_valid = 2'b00;  b1.rsp_ready = 2'b00;
        b1.req_dataA0 = 32'd0; b1.req_dataB0 = 32'd0; b1.req_Signal0 = 6'd0;
        b1.req_dataA1 = 32'd0; b1.req_dataB1 = 32'd0; b1.req_Signal1 = 6'd0;
        b4.req_valid = 2'b00;  b4.rsp_ready = 2'b00;
        b4.req_dataA0 = 32'd0; b4.req_dataB0 = 32'd0; b4.req_Signal0 = 6'd0;
        b4.req_dataA1 = 32'd0; b4.req_dataB1 = 32'd0; b4.req_Signal1 = 6'd0;
        tick();
        tick();

        // Reset values.
        chk("rst_req_ready",  32'(b1.req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(b1.rsp_valid),  32'd0);
        chk("rst_rsp_data",   b1.rsp_data,        32'd0);
        chk("rst_rsp_err",    32'(b1.rsp_err),    32'd0);
        chk("rst_alu_a",      b1.alu_dataA,       32'd0);
        chk("rst_alu_sig",    32'(b1.alu_Signal), 32'd0);
        chk("rst_alu_reset",  32'(b1.alu_reset),  32'd1);

        // Release with req0 ADD 5+7 already pending: grant after 2nd edge.
        b1.req_dataA0 = 32'd5; b1.req_dataB0 = 32'd7; b1.req_Signal0 = 6'd32;
        b1.req_valid  = 2'b01;
        b1.rsp_ready  = 2'b11;
        rst1 = 1'b1;
        tick();
        chk("rel_edge1_ready", 32'(b1.req_ready), 32'd0);
        tick();
        chk("rel_edge2_ready", 32'(b1.req_ready), 32'd1);
        issue1(1'b0, 6'd32, 32'd5, 32'd7);
        chk("add_exec_sig",   32'(b1.alu_Signal), 32'd32);
        chk("add_exec_a",     b1.alu_dataA,       32'd5);
        chk("add_exec_b",     b1.alu_dataB,       32'd7);
        chk("add_exec_reset", 32'(b1.alu_reset),  32'd0);
        chk("add_exec_ready", 32'(b1.req_ready),  32'd0);
        chk("add_exec_vld",   32'(b1.rsp_valid),  32'd0);
        tick();
        chk("add_rsp_vld",    32'(b1.rsp_valid),  32'd1);
        chk("add_rsp_data",   b1.rsp_data,        32'd12);
        chk("add_rsp_err",    32'(b1.rsp_err),    32'd0);
        chk("add_rsp_areset", 32'(b1.alu_reset),  32'd1);
        chk("add_rsp_sig",    32'(b1.alu_Signal), 32'd0);
        tick();
        chk("add_done_vld",   32'(b1.rsp_valid),  32'd0);
        chk("add_done_data",  b1.rsp_data,        32'd0);

        // Remaining opcodes.
        op1("sub", 1'b1, 6'd34, 32'd3, 32'd5, 32'hFFFF_FFFE);
        op1("slt", 1'b1, 6'd42, 32'd3, 32'd5, 32'd1);
        op1("and", 1'b0, 6'd36, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        op1("or",  1'b0, 6'd37, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);

        // Illegal opcode 0: answered next cycle without using the ALU.
        issue1(1'b0, 6'd0, 32'd9, 32'd9);
        chk("ill_vld",    32'(b1.rsp_valid),  32'd1);
        chk("ill_data",   b1.rsp_data,        32'd0);
        chk("ill_err",    32'(b1.rsp_err),    32'd1);
        chk("ill_areset", 32'(b1.alu_reset),  32'd1);
        chk("ill_sig",    32'(b1.alu_Signal), 32'd0);
        tick();
        chk("ill_done",   32'(b1.rsp_valid),  32'd0);
        chk("ill_areset2", 32'(b1.alu_reset), 32'd1);

        // Back-pressure on req0's response; req1 waits and its rsp_ready
        // must not end req0's response.
        b1.rsp_ready = 2'b00;
        issue1(1'b0, 6'd32, 32'd100, 32'd23);
        tick();
        b1.req_dataA1 = 32'd10; b1.req_dataB1 = 32'd4; b1.req_Signal1 = 6'd34;
        b1.req_valid[1] = 1'b1;
        b1.rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("hold_vld",   32'(b1.rsp_valid), 32'd1);
            chk("hold_data",  b1.rsp_data,       32'd123);
            chk("hold_err",   32'(b1.rsp_err),   32'd0);
            chk("hold_ready", 32'(b1.req_ready), 32'd0);
            tick();
        end
        b1.rsp_ready = 2'b01;
        tick();
        chk("hold_released", 32'(b1.rsp_valid), 32'd0);
        chk("pending_grant", 32'(b1.req_ready), 32'd2);
        b1.rsp_ready = 2'b11;
        issue1(1'b1, 6'd34, 32'd10, 32'd4);
        tick();
        chk("pend_vld",  32'(b1.rsp_valid), 32'd2);
        chk("pend_data", b1.rsp_data,       32'd6);
        tick();

        // dut4: both requesters valid continuously from reset release.
        b4.req_dataA0 = 32'd1;  b4.req_dataB0 = 32'd1;  b4.req_Signal0 = 6'd32;
        b4.req_dataA1 = 32'd10; b4.req_dataB1 = 32'd10; b4.req_Signal1 = 6'd32;
        b4.rsp_ready = 2'b11;
        b4.req_valid = 2'b11;
        rst4 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (b4.rsp_valid === 2'b00 && k < 40) begin
                tick();
                k++;
            end
            chk("rr_wait", 32'(k < 40), 32'd1);
`ifdef ALU_ARB_PRIO_EN
            exp_v = 2'b01;
`else
            exp_v = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("rr_grant", 32'(b4.rsp_valid), 32'(exp_v));
            chk("rr_data",  b4.rsp_data, (exp_v == 2'b01) ? 32'd2 : 32'd20);
            tick();
        end

        // Reset in the middle of a 4-cycle EXEC.
        k = 0;
        while (b4.alu_reset === 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("exec_wait", 32'(k < 20), 32'd1);
        tick();
        chk("exec_mid_areset", 32'(b4.alu_reset), 32'd0);
        rst4 = 1'b0;
        #1;
        chk("mid_rst_ready",  32'(b4.req_ready),  32'd0);
        chk("mid_rst_vld",    32'(b4.rsp_valid),  32'd0);
        chk("mid_rst_data",   b4.rsp_data,        32'd0);
        chk("mid_rst_err",    32'(b4.rsp_err),    32'd0);
        chk("mid_rst_a",      b4.alu_dataA,       32'd0);
        chk("mid_rst_b",      b4.alu_dataB,       32'd0);
        chk("mid_rst_sig",    32'(b4.alu_Signal), 32'd0);
        chk("mid_rst_areset", 32'(b4.alu_reset),  32'd1);
        b4.req_valid = 2'b00;
        tick();
        rst4 = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (b4.rsp_valid !== 2'b00) seen = 1'b1;
        end
        chk("no_stale_rsp", 32'(seen), 32'd0);

        // Block still works after the interrupted operation.
        b4.req_valid = 2'b01;
        k = 0;
        while (b4.rsp_valid === 2'b00 && k < 40) begin
            tick();
            if (b4.req_ready[0] === 1'b1) begin
                @(posedge clk);
                #1;
                b4.req_valid = 2'b00;
            end
            k++;
        end
        chk("post_rst_wait", 32'(k < 40), 32'd1);
        chk("post_rst_vld",  32'(b4.rsp_valid), 32'd1);
        chk("post_rst_data", b4.rsp_data,       32'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
